// File: rtl/mux_sel_arb_pkg.sv
// rtl/mux_sel_arb_pkg.sv - flit-type codes and arbiter state encoding for mux_sel_arb
package mux_sel_arb_pkg;

   localparam logic [1:0] TYPE_NONE = 2'd0;
   localparam logic [1:0] TYPE_HEAD = 2'd1;
   localparam logic [1:0] TYPE_DATA = 2'd2;
   localparam logic [1:0] TYPE_TAIL = 2'd3;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mux_sel_arb_rr_pick.sv
// rtl/mux_sel_arb_rr_pick.sv - combinational round-robin picker, first req at or above rr_ptr
module rr_pick #(
   parameter int N  = 5,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [N-1:0]  gnt,
   output logic          any
);

   int            idx;
   logic [PW-1:0] idx_w;

   always_comb begin
      gnt   = '0;
      any   = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N) idx = idx - N;
         idx_w = PW'(idx);
         if (!any && req[idx_w]) begin
            gnt[idx_w] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arb.sv
// rtl/mux_sel_arb.sv - packet-level round-robin allocator driving the one-hot output mux select
module mux_sel_arb
   import mux_sel_arb_pkg::*;
#(
   parameter int NPORT = 5,
   parameter int TYPEW = 2,
   parameter int LENW  = 8
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT-1:0]       ivalid,
   input  logic [NPORT*TYPEW-1:0] itype,
   input  logic                   ordy,
   output logic [NPORT-1:0]       sel,
   output logic [NPORT-1:0]       iack,
   output logic                   busy,
   output logic [LENW-1:0]        pkt_len
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(TYPE_HEAD);
   localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(TYPE_TAIL);

   arb_state_t       state, state_nxt;
   logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [NPORT-1:0] sel_nxt, req, is_tail, gnt, xfer;
   logic             busy_nxt, any, tail_xfer;
   logic [LENW-1:0]  len_nxt;
   logic [PW-1:0]    gidx;

   always_comb begin
      req     = '0;
      is_tail = '0;
      for (int n = 0; n < NPORT; n++) begin
         req[n]     = ivalid[n] && (itype[n*TYPEW +: TYPEW] == T_HEAD);
         is_tail[n] = (itype[n*TYPEW +: TYPEW] == T_TAIL);
      end
   end

   // sel is one-hot or zero, so xfer can have at most one bit set
   assign xfer      = sel & ivalid & {NPORT{ordy}};
   assign iack      = xfer;
   assign tail_xfer = |(xfer & is_tail);

   rr_pick #(.N(NPORT), .PW(PW)) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (gnt),
      .any    (any)
   );

   always_comb begin
      gidx = '0;
      for (int n = 0; n < NPORT; n++) begin
         if (sel[n]) gidx = PW'(n);
      end
   end

   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      busy_nxt   = busy;
      len_nxt    = pkt_len;
      rr_ptr_nxt = rr_ptr;
      case (state)
         ARB_IDLE: begin
            if (any) begin
               sel_nxt   = gnt;
               busy_nxt  = 1'b1;
               len_nxt   = '0;
               state_nxt = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (|xfer && (pkt_len != {LENW{1'b1}})) len_nxt = pkt_len + LENW'(1);
            // Dropping to IDLE with sel=0 gives the mandatory one-cycle bubble after a tail
            if (tail_xfer) begin
               sel_nxt    = '0;
               busy_nxt   = 1'b0;
               rr_ptr_nxt = (gidx == PW'(NPORT-1)) ? '0 : gidx + PW'(1);
               state_nxt  = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= ARB_IDLE;
         rr_ptr  <= '0;
         sel     <= '0;
         busy    <= 1'b0;
         pkt_len <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         sel     <= sel_nxt;
         busy    <= busy_nxt;
         pkt_len <= len_nxt;
      end
   end

endmodule

// File: tb/tb_mux_sel_arb.sv
// tb/tb_mux_sel_arb.sv - randomized self-checking bench for mux_sel_arb against a packet-level model
module tb_mux_sel_arb;
   import mux_sel_arb_pkg::*;

   localparam int NPORT = 5;
   localparam int TYPEW = 2;
   localparam int LENW  = 8;
   localparam int PW    = 3;
   localparam int LMAX  = (1 << LENW) - 1;

   logic                   clk = 1'b0;
   logic                   rst_ = 1'b0;
   logic [NPORT-1:0]       ivalid = '0;
   logic [NPORT*TYPEW-1:0] itype = '0;
   logic                   ordy = 1'b0;
   logic [NPORT-1:0]       sel, iack;
   logic                   busy;
   logic [LENW-1:0]        pkt_len;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0]       q[NPORT][$];
   int               vprob = 100;
   int               rprob = 100;
   int               cyc = 0;
   bit               stall_chk = 0;
   bit               m_locked;
   int               m_g, m_ptr, m_len;
   int               ack_cnt[NPORT];
   int               glog[$];
   int               gcyc[$];
   logic [NPORT-1:0] prev_sel;

   mux_sel_arb #(.NPORT(NPORT), .TYPEW(TYPEW), .LENW(LENW)) dut (
      .clk     (clk),
      .rst_    (rst_),
      .ivalid  (ivalid),
      .itype   (itype),
      .ordy    (ordy),
      .sel     (sel),
      .iack    (iack),
      .busy    (busy),
      .pkt_len (pkt_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit bit_at(input logic [NPORT-1:0] x, input int i);
      return x[PW'(i)];
   endfunction

   task automatic model_reset();
      m_locked = 0; m_g = 0; m_ptr = 0; m_len = 0; prev_sel = '0;
      for (int n = 0; n < NPORT; n++) begin
         q[n].delete();
         ack_cnt[n] = 0;
      end
      glog.delete();
      gcyc.delete();
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      ivalid = '0;
      @(posedge clk);
      #1;
      model_reset();
      rst_ = 1'b1;
   endtask

   task automatic push_pkt(input int n, input int nbody, input bit rnd_body);
      q[n].push_back(TYPE_HEAD);
      for (int k = 0; k < nbody; k++) begin
         if (rnd_body) begin
            case ($urandom_range(2))
               0: q[n].push_back(TYPE_DATA);
               1: q[n].push_back(TYPE_NONE);
               default: q[n].push_back(TYPE_HEAD);
            endcase
         end else begin
            q[n].push_back(TYPE_DATA);
         end
      end
      q[n].push_back(TYPE_TAIL);
   endtask

   task automatic cycle();
      logic [NPORT-1:0] v, ex, es;
      logic [1:0]       t[NPORT];
      bit               o, was_locked;
      int               wg;
      v = '0;
      for (int n = 0; n < NPORT; n++) begin
         if (q[n].size() > 0) begin
            t[n] = q[n][0];
            if ($urandom_range(99) < vprob) v = v | (NPORT'(1) << n);
         end else begin
            t[n] = 2'($urandom_range(3));
         end
         itype[n*TYPEW +: TYPEW] = t[n];
      end
      o = ($urandom_range(99) < rprob);
      ivalid = v;
      ordy = o;
      es = m_locked ? (NPORT'(1) << m_g) : '0;
      ex = (m_locked && bit_at(v, m_g) && o) ? (NPORT'(1) << m_g) : '0;

      @(negedge clk);
      check("sel", 32'(sel), 32'(es));
      check("busy", 32'(busy), 32'(m_locked));
      check("pkt_len", 32'(pkt_len), 32'(m_len));
      check("iack", 32'(iack), 32'(ex));
      if (stall_chk) begin
         check("bp_sel", 32'(sel), 32'(5'b01000));
         check("bp_iack", 32'(iack), 32'(0));
      end
      for (int n = 0; n < NPORT; n++) if (iack[n]) ack_cnt[n]++;
      if (sel != '0 && prev_sel == '0) begin
         for (int n = 0; n < NPORT; n++) if (sel[n]) glog.push_back(n);
         gcyc.push_back(cyc);
      end
      prev_sel = sel;

      @(posedge clk);
      was_locked = m_locked;
      wg = m_g;
      if (m_locked) begin
         if (bit_at(v, m_g) && o) begin
            if (m_len < LMAX) m_len++;
            if (t[m_g] == TYPE_TAIL) begin
               m_locked = 0;
               m_ptr = (m_g + 1) % NPORT;
            end
         end
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            int p;
            p = (m_ptr + i) % NPORT;
            if (bit_at(v, p) && t[p] == TYPE_HEAD) begin
               m_locked = 1; m_g = p; m_len = 0;
               break;
            end
         end
      end
      // consumed flits leave the source; stray non-head flits on unlocked ports are dropped
      for (int n = 0; n < NPORT; n++) begin
         if (q[n].size() > 0 && bit_at(v, n)) begin
            if (bit_at(ex, n)) void'(q[n].pop_front());
            else if (!(was_locked && wg == n) && q[n][0] != TYPE_HEAD) void'(q[n].pop_front());
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      int start;
      int exp3[4];
      exp3 = '{0, 2, 4, 0};
      model_reset();

      // reset held with random inputs
      rst_ = 1'b0;
      for (int c = 0; c < 6; c++) begin
         ivalid = NPORT'($urandom);
         itype  = (NPORT*TYPEW)'($urandom);
         ordy   = 1'($urandom);
         @(negedge clk);
         check("rst_sel", 32'(sel), 32'(0));
         check("rst_busy", 32'(busy), 32'(0));
         check("rst_len", 32'(pkt_len), 32'(0));
         check("rst_iack", 32'(iack), 32'(0));
         @(posedge clk);
         #1;
      end
      do_reset();

      // single packet on port 1
      push_pkt(1, 20, 0);
      start = cyc;
      for (int c = 0; c < 26; c++) cycle();
      check("t2_ngrant", 32'(glog.size()), 32'(1));
      if (glog.size() > 0) begin
         check("t2_port", 32'(glog[0]), 32'(1));
         check("t2_latency", 32'(gcyc[0] - start), 32'(1));
      end
      check("t2_acks", 32'(ack_cnt[1]), 32'(22));
      check("t2_len", 32'(pkt_len), 32'(22));
      check("t2_sel", 32'(sel), 32'(0));
      check("t2_rr_ptr", 32'(dut.rr_ptr), 32'(2));

      // round robin across ports 0, 2, 4
      do_reset();
      push_pkt(0, 1, 0); push_pkt(2, 1, 0); push_pkt(4, 1, 0); push_pkt(0, 1, 0);
      for (int c = 0; c < 24; c++) cycle();
      check("t3_ngrant", 32'(glog.size()), 32'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < glog.size()) check("t3_order", 32'(glog[k]), 32'(exp3[k]));
         if (k > 0 && k < gcyc.size()) check("t3_gap", 32'(gcyc[k] - gcyc[k-1]), 32'(4));
      end

      // backpressure inside a packet on port 3
      do_reset();
      push_pkt(3, 12, 0);
      for (int c = 0; c < 30; c++) begin
         stall_chk = (c >= 5 && c <= 9);
         rprob = stall_chk ? 0 : 100;
         cycle();
      end
      stall_chk = 0;
      rprob = 100;
      check("t4_acks", 32'(ack_cnt[3]), 32'(14));
      check("t4_len", 32'(pkt_len), 32'(14));

      // rr_ptr is now 4: wrap to port 0, then port 1; port 2 only sends body flits
      glog.delete(); gcyc.delete();
      push_pkt(0, 0, 0); push_pkt(1, 0, 0);
      for (int k = 0; k < 10; k++) q[2].push_back(TYPE_DATA);
      for (int c = 0; c < 15; c++) cycle();
      check("t5_ngrant", 32'(glog.size()), 32'(2));
      if (glog.size() >= 2) begin
         check("t5_first", 32'(glog[0]), 32'(0));
         check("t5_second", 32'(glog[1]), 32'(1));
      end
      check("t5_port2_acks", 32'(ack_cnt[2]), 32'(0));

      // reset mid-packet
      do_reset();
      push_pkt(1, 15, 0);
      for (int c = 0; c < 40 && ack_cnt[1] < 10; c++) cycle();
      check("t6_reach10", 32'(ack_cnt[1]), 32'(10));
      #2;
      rst_ = 1'b0;
      #1;
      check("t6_async_sel", 32'(sel), 32'(0));
      check("t6_async_busy", 32'(busy), 32'(0));
      check("t6_async_iack", 32'(iack), 32'(0));
      check("t6_async_len", 32'(pkt_len), 32'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      push_pkt(0, 0, 0); push_pkt(1, 0, 0);
      for (int c = 0; c < 8; c++) cycle();
      check("t6_ngrant", 32'(glog.size()), 32'(2));
      if (glog.size() > 0) check("t6_first", 32'(glog[0]), 32'(0));

      // pkt_len saturation on a long packet
      do_reset();
      push_pkt(2, 300, 0);
      for (int c = 0; c < 306; c++) cycle();
      check("sat_len", 32'(pkt_len), 32'(LMAX));
      check("sat_acks", 32'(ack_cnt[2]), 32'(302));

      // random traffic
      do_reset();
      vprob = 75;
      rprob = 80;
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < NPORT; n++) begin
            if (q[n].size() == 0 && $urandom_range(2) == 0) begin
               if ($urandom_range(3) == 0) q[n].push_back(TYPE_DATA);
               push_pkt(n, $urandom_range(4), 1);
            end
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
